// File: rtl/mem_stage_if.sv
// Memory-stage bus: EX/MEM pipeline inputs and MEM/WB registered outputs.
// The master drives the _M side and observes the _W side. The slave is the stage itself.
interface mem_stage_if;
    logic [31:0] ALUResult_M;
    logic [31:0] din_M;
    logic [4:0]  RdOrRt_M;
    logic        RegWrite_M;
    logic        MemtoReg_M;
    logic        MemWrite_M;

    logic [31:0] ReadData_W;
    logic [31:0] ALUResult_W;
    logic [4:0]  RdOrRt_W;
    logic        RegWrite_W;
    logic        MemtoReg_W;
    logic [31:0] Result_W;
    logic        MisalignErr;

    modport master (
        output ALUResult_M, din_M, RdOrRt_M, RegWrite_M, MemtoReg_M, MemWrite_M,
        input  ReadData_W, ALUResult_W, RdOrRt_W, RegWrite_W, MemtoReg_W,
        input  Result_W, MisalignErr
    );

    modport slave (
        input  ALUResult_M, din_M, RdOrRt_M, RegWrite_M, MemtoReg_M, MemWrite_M,
        output ReadData_W, ALUResult_W, RdOrRt_W, RegWrite_W, MemtoReg_W,
        output Result_W, MisalignErr
    );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage with a 2^AW x 32-bit data memory and a MEM/WB register.
// Loads see the pre-edge word contents. A store becomes visible to a load on the next edge.
// Optional feature macro: DMEM_ALIGN_CHECK_EN. When it is defined, misaligned accesses are
// suppressed and raise a sticky MisalignErr. When it is undefined, address bits [1:0] are ignored.
module mem_stage #(
    parameter int AW = 8
) (
    input  logic        clk,
    input  logic        reset,
    mem_stage_if.slave  bus
);

    logic [31:0]   mem [0:(1<<AW)-1];
    logic [AW-1:0] word_idx;
    logic          misalign;
    logic          write_en;

    assign word_idx = bus.ALUResult_M[AW+1:2];

`ifdef DMEM_ALIGN_CHECK_EN
    assign misalign = (bus.MemWrite_M | bus.MemtoReg_M) & (bus.ALUResult_M[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    // Reset only blocks writes here. The memory contents themselves are never cleared.
    assign write_en = bus.MemWrite_M & ~misalign & ~reset;

    // Data memory write port
    always_ff @(posedge clk) begin
        if (write_en) begin
            mem[word_idx] <= bus.din_M;
        end
    end

    // MEM/WB register: captures pre-write read data and the pass-through fields every edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.ReadData_W  <= 32'h0;
            bus.ALUResult_W <= 32'h0;
            bus.RdOrRt_W    <= 5'h0;
            bus.RegWrite_W  <= 1'b0;
            bus.MemtoReg_W  <= 1'b0;
        end else begin
            bus.ReadData_W  <= misalign ? 32'h0 : mem[word_idx];
            bus.ALUResult_W <= bus.ALUResult_M;
            bus.RdOrRt_W    <= bus.RdOrRt_M;
            bus.RegWrite_W  <= bus.RegWrite_M;
            bus.MemtoReg_W  <= bus.MemtoReg_M;
        end
    end

`ifdef DMEM_ALIGN_CHECK_EN
    logic misalign_err_q;

    // Sticky misalignment flag, cleared only by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            misalign_err_q <= 1'b0;
        end else if (misalign) begin
            misalign_err_q <= 1'b1;
        end
    end

    assign bus.MisalignErr = misalign_err_q;
`else
    assign bus.MisalignErr = 1'b0;
`endif

    // Writeback mux, purely combinational from the W registers
    assign bus.Result_W = bus.MemtoReg_W ? bus.ReadData_W : bus.ALUResult_W;

endmodule
